// File: rtl/apple_pkg.sv
// Shared types and constants for the apple placement block.
// The optional scan fallback is enabled with APPLE_LINEAR_FALLBACK_EN.
package apple_pkg;

  localparam int unsigned X_W    = 7;
  localparam int unsigned Y_W    = 6;
  localparam int unsigned LFSR_W = 16;
  localparam int unsigned TRY_W  = 6;
  localparam int unsigned CNT_W  = 8;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shift register
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK     = 16'h002D;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GEN     = 3'd1,
    CHECK   = 3'd2,
    WAIT_VB = 3'd3,
    FAIL    = 3'd4,
    SCAN    = 3'd5
  } state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } cell_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAP_MASK), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/apple_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; loads its seed on reset and never
// accepts the all-zero lock-up state as a seed.
module apple_lfsr
  import apple_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [LFSR_W-1:0] lfsr_o
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_DEFAULT_SEED : SEED;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/apple_ctrl.sv
// Apple placement sequencer: draws LFSR candidates, checks them against the snake
// occupancy store and commits a free cell during vertical blank.
// Define APPLE_LINEAR_FALLBACK_EN to raster-scan the grid once random tries run out.
module apple_ctrl
  import apple_pkg::*;
#(
  parameter int unsigned       GRID_COLS = 80,
  parameter int unsigned       GRID_ROWS = 60,
  parameter int unsigned       MAX_TRIES = 32,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             spawn_req,
  input  logic             eaten,
  input  logic             vblnk_in,
  output logic             occ_req,
  output logic [X_W-1:0]   occ_x,
  output logic [Y_W-1:0]   occ_y,
  input  logic             occ_ack,
  input  logic             occ_hit,
  output logic [X_W-1:0]   apple_x,
  output logic [Y_W-1:0]   apple_y,
  output logic             apple_valid,
  output logic             busy,
  output logic             place_fail,
  output logic [CNT_W-1:0] apple_count
);

  localparam logic [X_W:0]       COLS_L = 8'(GRID_COLS);
  localparam logic [Y_W:0]       ROWS_L = 7'(GRID_ROWS);
  localparam logic [TRY_W-1:0]   MAX_T  = 6'(MAX_TRIES);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

`ifdef APPLE_LINEAR_FALLBACK_EN
  localparam state_e EXHAUST_ST = SCAN;
`else
  localparam state_e EXHAUST_ST = FAIL;
`endif

  logic [LFSR_W-1:0] lfsr_w;
  logic              unused_lfsr;

  state_e           state_q, state_d;
  logic             spawn_q, eaten_q;
  logic             pending_q, pending_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             occ_req_q, occ_req_d;
  cell_t            occ_q, occ_d;
  cell_t            apple_q, apple_d;
  logic             apple_valid_q, apple_valid_d;
  logic             place_fail_q, place_fail_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;

  cell_t            cand;
  logic             cand_oor;
  logic [TRY_W-1:0] tries_inc;
  logic             tries_done;

  apple_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk_i (pclk),
    .rst_ni(rst),
    .lfsr_o(lfsr_w)
  );

  assign unused_lfsr = ^{lfsr_w[15:14], lfsr_w[7]};

  assign cand       = {lfsr_w[X_W-1:0], lfsr_w[8+Y_W-1:8]};
  assign cand_oor   = ({1'b0, cand.x} >= COLS_L) || ({1'b0, cand.y} >= ROWS_L);
  assign tries_inc  = tries_q + 6'd1;
  assign tries_done = (tries_inc >= MAX_T);

`ifdef APPLE_LINEAR_FALLBACK_EN
  cell_t scan_q, scan_d;
  logic  scan_mode_q, scan_mode_d;
  logic  scan_last;
  cell_t scan_next;

  assign scan_last = (scan_q.x == 7'(GRID_COLS - 1)) && (scan_q.y == 6'(GRID_ROWS - 1));
  assign scan_next = (scan_q.x == 7'(GRID_COLS - 1)) ? {7'd0, scan_q.y + 6'd1}
                                                     : {scan_q.x + 7'd1, scan_q.y};
`endif

  // Next-state and output-register logic
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    tries_d       = tries_q;
    occ_req_d     = occ_req_q;
    occ_d         = occ_q;
    apple_d       = apple_q;
    apple_valid_d = apple_valid_q;
    place_fail_d  = place_fail_q;
    count_d       = count_q;
`ifdef APPLE_LINEAR_FALLBACK_EN
    scan_d        = scan_q;
    scan_mode_d   = scan_mode_q;
`endif

    if (eaten && (count_q != CNT_MAX)) begin
      count_d = count_q + 8'd1;
    end
    if (eaten_q && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (spawn_q || eaten_q || pending_q) begin
          place_fail_d = 1'b0;
          pending_d    = 1'b0;
          tries_d      = '0;
          state_d      = GEN;
`ifdef APPLE_LINEAR_FALLBACK_EN
          scan_d       = '0;
          scan_mode_d  = 1'b0;
`endif
        end
        if (eaten_q) begin
          apple_valid_d = 1'b0;
        end
      end

      GEN: begin
        if (tries_q >= MAX_T) begin
          state_d = EXHAUST_ST;
        end else if (cand_oor) begin
          tries_d = tries_inc;
          if (tries_done) begin
            state_d = EXHAUST_ST;
          end
        end else begin
          occ_d     = cand;
          occ_req_d = 1'b1;
          state_d   = CHECK;
        end
      end

      CHECK: begin
        if (occ_ack) begin
          occ_req_d = 1'b0;
          if (!occ_hit) begin
            state_d = WAIT_VB;
`ifdef APPLE_LINEAR_FALLBACK_EN
          end else if (scan_mode_q) begin
            if (scan_last) begin
              state_d = FAIL;
            end else begin
              scan_d  = scan_next;
              state_d = SCAN;
            end
`endif
          end else begin
            tries_d = tries_inc;
            state_d = tries_done ? EXHAUST_ST : GEN;
          end
        end
      end

      WAIT_VB: begin
        if (vblnk_in) begin
          apple_d       = occ_q;
          apple_valid_d = 1'b1;
          state_d       = IDLE;
        end
      end

      FAIL: begin
        place_fail_d = 1'b1;
        state_d      = IDLE;
      end

`ifdef APPLE_LINEAR_FALLBACK_EN
      SCAN: begin
        scan_mode_d = 1'b1;
        occ_d       = scan_q;
        occ_req_d   = 1'b1;
        state_d     = CHECK;
      end
`endif

      default: begin
        state_d   = IDLE;
        occ_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      spawn_q       <= 1'b0;
      eaten_q       <= 1'b0;
      pending_q     <= 1'b0;
      tries_q       <= '0;
      occ_req_q     <= 1'b0;
      occ_q         <= '0;
      apple_q       <= '0;
      apple_valid_q <= 1'b0;
      place_fail_q  <= 1'b0;
      busy_q        <= 1'b0;
      count_q       <= '0;
`ifdef APPLE_LINEAR_FALLBACK_EN
      scan_q        <= '0;
      scan_mode_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      spawn_q       <= spawn_req;
      eaten_q       <= eaten;
      pending_q     <= pending_d;
      tries_q       <= tries_d;
      occ_req_q     <= occ_req_d;
      occ_q         <= occ_d;
      apple_q       <= apple_d;
      apple_valid_q <= apple_valid_d;
      place_fail_q  <= place_fail_d;
      busy_q        <= busy_d;
      count_q       <= count_d;
`ifdef APPLE_LINEAR_FALLBACK_EN
      scan_q        <= scan_d;
      scan_mode_q   <= scan_mode_d;
`endif
    end
  end

  assign occ_req     = occ_req_q;
  assign occ_x       = occ_q.x;
  assign occ_y       = occ_q.y;
  assign apple_x     = apple_q.x;
  assign apple_y     = apple_q.y;
  assign apple_valid = apple_valid_q;
  assign busy        = busy_q;
  assign place_fail  = place_fail_q;
  assign apple_count = count_q;

endmodule

// File: tb/tb_apple_ctrl.sv
// Directed bench for apple_ctrl: cycle table for the spawn/eaten timeline plus
// sequences for reset, vblank hold, exhaustion, pending placements and saturation.
module tb_apple_ctrl;

  logic       pclk = 1'b0;
  logic       rst = 1'b0;
  logic       spawn_req = 1'b0;
  logic       eaten = 1'b0;
  logic       vblnk_in = 1'b1;
  logic       occ_req;
  logic [6:0] occ_x;
  logic [5:0] occ_y;
  logic       occ_ack;
  logic       occ_hit;
  logic [6:0] apple_x;
  logic [5:0] apple_y;
  logic       apple_valid;
  logic       busy;
  logic       place_fail;
  logic [7:0] apple_count;

  logic       ack_en = 1'b1;
  int         hit_mode = 0;   // 0 all free, 1 all occupied, 2 occupied except (5,2)

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_lfsr;
  logic [15:0] trig_lfsr;
  logic [12:0] q_log[$];
  int          place_cnt = 0;
  logic        busy_prev = 1'b0;

  apple_ctrl dut (
    .pclk       (pclk),
    .rst        (rst),
    .spawn_req  (spawn_req),
    .eaten      (eaten),
    .vblnk_in   (vblnk_in),
    .occ_req    (occ_req),
    .occ_x      (occ_x),
    .occ_y      (occ_y),
    .occ_ack    (occ_ack),
    .occ_hit    (occ_hit),
    .apple_x    (apple_x),
    .apple_y    (apple_y),
    .apple_valid(apple_valid),
    .busy       (busy),
    .place_fail (place_fail),
    .apple_count(apple_count)
  );

  always #5 pclk = ~pclk;

  // Occupancy store stand-in: answers in the same cycle as the request
  assign occ_ack = occ_req && ack_en;
  assign occ_hit = (hit_mode == 1) || ((hit_mode == 2) && !((occ_x == 7'd5) && (occ_y == 6'd2)));

  function automatic logic [15:0] nxt(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic in_rng(input logic [15:0] s);
    return (s[6:0] < 7'd80) && (s[13:8] < 6'd60);
  endfunction

  function automatic logic [12:0] cell_of(input logic [15:0] s);
    return {s[6:0], s[13:8]};
  endfunction

  function automatic logic [12:0] first_free(input logic [15:0] s);
    logic [15:0] g;
    g = s;
    for (int i = 0; i < 1000; i++) begin
      if (in_rng(g)) break;
      g = nxt(g);
    end
    return cell_of(g);
  endfunction

  always @(posedge pclk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= nxt(m_lfsr);
  end

  always @(negedge pclk) begin
    if (rst && occ_req && occ_ack) q_log.push_back({occ_x, occ_y});
    if (busy && !busy_prev) place_cnt++;
    busy_prev = busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic pulse(input logic sp, input logic ea);
    spawn_req = sp;
    eaten     = ea;
    trig_lfsr = m_lfsr;
    tick();
    spawn_req = 1'b0;
    eaten     = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int run;
    int cyc;
    run = 0;
    cyc = 0;
    tick();
    tick();
    while ((run < 4) && (cyc < budget)) begin
      tick();
      cyc++;
      if (!busy) run++;
      else       run = 0;
    end
    if (run < 4) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
    end
  endtask

  typedef struct {
    logic       spawn;
    logic       eaten;
    logic       vb;
    logic       exp_busy;
    logic       exp_req;
    logic       exp_valid;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [12:0] prev_cell;
    logic [12:0] exp_cell;
    logic [15:0] g;
    logic [12:0] exp_q[$];
    int          tries;
    int          mism;
    int          p0;
    int          c0;
    int          guard;

    //           spawn  eaten  vb     busy   req    valid  count
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};

    // Reset asserted while a query is outstanding
    repeat (3) tick();
    rst = 1'b1;
    tick();
    ack_en = 1'b0;
    pulse(1'b0, 1'b1);
    guard = 0;
    while (!occ_req && guard < 60) begin
      tick();
      guard++;
    end
    check("pre_reset_req", 32'(occ_req), 32'd1);
    check("pre_reset_cnt", 32'(apple_count), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("rst_occ_req", 32'(occ_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outputs", 32'({apple_x, apple_y, apple_valid, place_fail, apple_count, occ_x, occ_y}), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("rst_lfsr_seed", 32'(dut.lfsr_w), 32'hACE1);
    ack_en = 1'b1;
    tick();
    check("lfsr_model_sync", 32'(dut.lfsr_w), 32'(m_lfsr));

    // Align so the first candidate is in range, then run the cycle table
    guard = 0;
    while (!in_rng(nxt(nxt(m_lfsr))) && guard < 100) begin
      tick();
      guard++;
    end
    for (int i = 0; i < 7; i++) begin
      spawn_req = vecs[i].spawn;
      eaten     = vecs[i].eaten;
      vblnk_in  = vecs[i].vb;
      if (vecs[i].spawn || vecs[i].eaten) trig_lfsr = m_lfsr;
      if (i == 0) exp_cell = cell_of(nxt(nxt(m_lfsr)));
      tick();
      spawn_req = 1'b0;
      eaten     = 1'b0;
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_req", i), 32'(occ_req), 32'(vecs[i].exp_req));
      check($sformatf("vec%0d_valid", i), 32'(apple_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_count", i), 32'(apple_count), 32'(vecs[i].exp_cnt));
      if (i == 4) begin
        check("latency_cell", 32'({apple_x, apple_y}), 32'(exp_cell));
        prev_cell = {apple_x, apple_y};
      end
    end

    // Replacement found with vblank low must wait for the blank
    exp_cell = first_free(nxt(nxt(trig_lfsr)));
    repeat (100) tick();
    check("vb_hold_busy", 32'(busy), 32'd1);
    check("vb_hold_valid", 32'(apple_valid), 32'd0);
    check("vb_hold_cell", 32'({apple_x, apple_y}), 32'(prev_cell));
    vblnk_in = 1'b1;
    tick();
    check("vb_commit_valid", 32'(apple_valid), 32'd1);
    check("vb_commit_busy", 32'(busy), 32'd0);
    check("vb_commit_cell", 32'({apple_x, apple_y}), 32'(exp_cell));

    // Every query occupied: random tries exhaust
    hit_mode = 1;
    q_log.delete();
    pulse(1'b0, 1'b1);
    g = nxt(nxt(trig_lfsr));
    tries = 0;
    exp_q.delete();
    while (tries < 32) begin
      if (!in_rng(g)) begin
        g = nxt(g);
      end else begin
        exp_q.push_back(cell_of(g));
        g = nxt(nxt(g));
      end
      tries++;
    end
    wait_idle("fail_idle", 20000);
`ifdef APPLE_LINEAR_FALLBACK_EN
    check("fail_nq", 32'(q_log.size()), 32'(exp_q.size() + 4800));
    if (q_log.size() > 0) check("scan_last_cell", 32'(q_log[q_log.size()-1]), 32'({7'd79, 6'd59}));
`else
    check("fail_nq", 32'(q_log.size()), 32'(exp_q.size()));
`endif
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= q_log.size() || q_log[i] != exp_q[i]) mism++;
    end
    check("fail_qseq", 32'(mism), 32'd0);
    check("fail_flag", 32'(place_fail), 32'd1);
    check("fail_valid", 32'(apple_valid), 32'd0);

    hit_mode = 0;
    pulse(1'b1, 1'b0);
    wait_idle("respawn_idle", 500);
    check("respawn_fail_clr", 32'(place_fail), 32'd0);
    check("respawn_valid", 32'(apple_valid), 32'd1);

`ifdef APPLE_LINEAR_FALLBACK_EN
    // Only (5,2) free: scan must land on it
    hit_mode = 2;
    pulse(1'b0, 1'b1);
    wait_idle("scan_idle", 5000);
    check("scan_cell", 32'({apple_x, apple_y}), 32'({7'd5, 6'd2}));
    check("scan_valid", 32'(apple_valid), 32'd1);
    check("scan_fail", 32'(place_fail), 32'd0);
    hit_mode = 0;
`endif

    // Eaten while busy queues exactly one more placement; spawn while busy ignored
    p0 = place_cnt;
    c0 = int'(apple_count);
    ack_en = 1'b0;
    pulse(1'b1, 1'b0);
    repeat (3) tick();
    pulse(1'b0, 1'b1);
    tick();
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    repeat (3) tick();
    ack_en = 1'b1;
    wait_idle("pend_idle", 500);
    check("pend_places", 32'(place_cnt - p0), 32'd2);
    check("pend_count", 32'(int'(apple_count) - c0), 32'd2);

    // spawn_req and eaten together: one placement, one count
    p0 = place_cnt;
    c0 = int'(apple_count);
    pulse(1'b1, 1'b1);
    wait_idle("coinc_idle", 500);
    check("coinc_places", 32'(place_cnt - p0), 32'd1);
    check("coinc_count", 32'(int'(apple_count) - c0), 32'd1);

    // Count saturates
    eaten = 1'b1;
    repeat (300) tick();
    eaten = 1'b0;
    wait_idle("sat_idle", 500);
    check("count_sat", 32'(apple_count), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
